// File: rtl/display_command_scheduler_if.sv
// Handshake bundle between the byte/test sources and the scheduler.
// Carries the UART byte strobe and the test-pattern request/grant pair.
interface display_command_scheduler_if #(
  parameter int ID_W = 6
);
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            test_req;
  logic [ID_W-1:0] test_id;
  logic            test_gnt;

  modport master (
    output rx_valid,
    output rx_data,
    output test_req,
    output test_id,
    input  test_gnt
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    input  test_req,
    input  test_id,
    output test_gnt
  );
endinterface

// File: rtl/display_command_scheduler.sv
// Parses header/ID/checksum frames and arbitrates the display with a test source.
// Ports: clk, nRESET, bus (rx/test handshake), id_out, id_valid, frame_err, busy.
module display_command_scheduler #(
  parameter int          ID_W           = 6,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int          HOLD_CYCLES    = 1000,
  parameter int          TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          nRESET,
  display_command_scheduler_if.slave    bus,
  output logic [ID_W-1:0]               id_out,
  output logic                          id_valid,
  output logic                          frame_err,
  output logic                          busy
);

  localparam int GW = $clog2(TIMEOUT_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);

  localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    P_IDLE,
    P_ID,
    P_CHK
  } p_state_t;

  typedef enum logic {
    D_IDLE,
    D_SHOW
  } d_state_t;

  p_state_t        p_state;
  d_state_t        d_state;
  logic [ID_W-1:0] cand_id;
  logic [GW-1:0]   gap;
  logic [HW-1:0]   hold;

  logic       is_hdr;
  logic       id_ok;
  logic [7:0] chk_byte;
  logic       frame_done;
  logic       timeout;
  logic       grant;
  logic       hold_done;

  assign is_hdr   = bus.rx_valid && (bus.rx_data == HEADER);
  assign id_ok    = (bus.rx_data >> ID_W) == 8'd0;
  assign chk_byte = HEADER ^ 8'(cand_id);

  assign frame_done = (p_state == P_CHK) && bus.rx_valid
                   && (bus.rx_data == chk_byte);

  assign timeout = !bus.rx_valid && (p_state != P_IDLE)
                && (gap == GAP_LAST);

  // A header in the same cycle blocks the grant so the frame owns the display.
  assign grant = bus.test_req && (d_state == D_IDLE)
              && (p_state == P_IDLE) && !is_hdr;

  // A completing frame restarts the hold instead of letting it expire.
  assign hold_done = (d_state == D_SHOW) && (hold == '0) && !frame_done;

  assign busy = (p_state != P_IDLE) || (d_state != D_IDLE);

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      p_state   <= P_IDLE;
      cand_id   <= '0;
      gap       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (bus.rx_valid) begin
        gap <= '0;
        unique case (p_state)
          P_IDLE: begin
            if (is_hdr) p_state <= P_ID;
          end
          P_ID: begin
            if (id_ok) begin
              cand_id <= bus.rx_data[ID_W-1:0];
              p_state <= P_CHK;
            end else begin
              frame_err <= 1'b1;
              p_state   <= is_hdr ? P_ID : P_IDLE;
            end
          end
          P_CHK: begin
            frame_err <= !frame_done;
            p_state   <= P_IDLE;
          end
          default: p_state <= P_IDLE;
        endcase
      end else if (timeout) begin
        frame_err <= 1'b1;
        p_state   <= P_IDLE;
        gap       <= '0;
      end else if (p_state != P_IDLE) begin
        gap <= gap + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      d_state      <= D_IDLE;
      hold         <= '0;
      id_out       <= '0;
      id_valid     <= 1'b0;
      bus.test_gnt <= 1'b0;
    end else begin
      bus.test_gnt <= grant;
      unique case (1'b1)
        frame_done, grant: begin
          id_out   <= frame_done ? cand_id : bus.test_id;
          id_valid <= 1'b1;
          hold     <= HOLD_LAST;
          d_state  <= D_SHOW;
        end
        hold_done: begin
          id_out   <= '0;
          id_valid <= 1'b0;
          d_state  <= D_IDLE;
        end
        default: begin
          if (d_state == D_SHOW) hold <= hold - 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_command_scheduler.sv
// Scoreboard bench: a frame-level model predicts output events per edge.
// A negedge monitor turns DUT output changes into events and compares.
module tb_display_command_scheduler;

  localparam int         HOLD = 8;
  localparam int         TO   = 16;
  localparam logic [7:0] HDR  = 8'hA5;

  localparam int K_ERR   = 0;
  localparam int K_GNT   = 1;
  localparam int K_SHOW  = 2;
  localparam int K_BLANK = 3;
  localparam int K_BUSY  = 4;

  typedef struct {
    int kind;
    int val;
    int e;
  } ev_t;

  logic       clk = 1'b0;
  logic       nRESET = 1'b0;
  logic [5:0] id_out;
  logic       id_valid;
  logic       frame_err;
  logic       busy;

  display_command_scheduler_if #(.ID_W(6)) bus();

  display_command_scheduler #(
    .ID_W(6),
    .HEADER(HDR),
    .HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .nRESET(nRESET),
    .bus(bus),
    .id_out(id_out),
    .id_valid(id_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int  n_chk = 0;
  int  n_fail = 0;
  ev_t exp_q[$];
  bit  mon_en = 0;

  // model state
  logic [7:0] frame_q[$];
  int         last_e = 0;
  bit         show_on = 0;
  int         show_id = 0;
  int         show_until = 0;
  bit         busy_prev = 0;

  bit         treq_lvl = 0;
  logic [5:0] tid_lvl = '0;

  bit         pv = 0;
  int         pid = 0;
  bit         pb = 0;

  function automatic string kname(input int k);
    case (k)
      K_ERR:   return "frame_err";
      K_GNT:   return "test_gnt";
      K_SHOW:  return "show";
      K_BLANK: return "blank";
      default: return "busy";
    endcase
  endfunction

  task automatic push(input int k, input int v, input int e);
    ev_t x;
    x.kind = k;
    x.val = v;
    x.e = e;
    exp_q.push_back(x);
  endtask

  task automatic cmp(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic observe(input int k, input int v);
    ev_t x;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected: val %0d at edge %0d",
               kname(k), v, edge_n);
    end else begin
      x = exp_q.pop_front();
      if (x.kind != k || x.val != v || x.e != edge_n) begin
        n_fail++;
        $display("FAIL %s: got val %0d at edge %0d, required %s val %0d at edge %0d",
                 kname(k), v, edge_n, kname(x.kind), x.val, x.e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_err) observe(K_ERR, 0);
      if (bus.test_gnt) observe(K_GNT, 0);
      if (id_valid && (!pv || int'(id_out) != pid))
        observe(K_SHOW, int'(id_out));
      if (!id_valid && pv) observe(K_BLANK, int'(id_out));
      if (busy != pb) observe(K_BUSY, int'(busy));
      while (exp_q.size() > 0 && exp_q[0].e <= edge_n) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s missing: required val %0d at edge %0d",
                 kname(exp_q[0].kind), exp_q[0].val, exp_q[0].e);
        void'(exp_q.pop_front());
      end
      pv = id_valid;
      pid = int'(id_out);
      pb = busy;
    end
  end

  // Frame-level reference: bytes collected so far, cycles since last byte,
  // and the edge at which the current display blanks.
  task automatic model(input int e, input bit rv, input logic [7:0] rd,
                       input bit treq, input logic [5:0] tid);
    int n0;
    bit err;
    bit done;
    bit gnt;
    bit bz;
    int nid;
    n0 = frame_q.size();
    err = 0;
    done = 0;
    nid = 0;
    if (rv) begin
      last_e = e;
      if (n0 == 0) begin
        if (rd == HDR) frame_q.push_back(rd);
      end else if (n0 == 1) begin
        if (rd < 8'd64) frame_q.push_back(rd);
        else begin
          err = 1;
          frame_q.delete();
          if (rd == HDR) frame_q.push_back(rd);
        end
      end else begin
        if (rd == (frame_q[0] ^ frame_q[1])) begin
          done = 1;
          nid = int'(frame_q[1]);
        end else err = 1;
        frame_q.delete();
      end
    end else if (n0 > 0 && e - last_e == TO) begin
      err = 1;
      frame_q.delete();
    end
    gnt = treq && !show_on && n0 == 0 && !(rv && rd == HDR);
    if (err) push(K_ERR, 0, e);
    if (gnt) push(K_GNT, 0, e);
    if (done || gnt) begin
      if (gnt) nid = int'(tid);
      if (!show_on || show_id != nid) push(K_SHOW, nid, e);
      show_on = 1;
      show_id = nid;
      show_until = e + HOLD;
    end else if (show_on && e == show_until) begin
      push(K_BLANK, 0, e);
      show_on = 0;
    end
    bz = frame_q.size() > 0 || show_on;
    if (bz != busy_prev) push(K_BUSY, int'(bz), e);
    busy_prev = bz;
  endtask

  task automatic cycle(input bit rv, input logic [7:0] rd);
    bus.rx_valid = rv;
    bus.rx_data = rd;
    bus.test_req = treq_lvl;
    bus.test_id = tid_lvl;
    model(edge_n + 1, rv, rd, treq_lvl, tid_lvl);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_id_out"}, int'(id_out), 0);
    cmp({tag, "_id_valid"}, int'(id_valid), 0);
    cmp({tag, "_frame_err"}, int'(frame_err), 0);
    cmp({tag, "_test_gnt"}, int'(bus.test_gnt), 0);
    cmp({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    mon_en = 0;
    bus.rx_valid = 1'b0;
    nRESET = 1'b0;
    #1;
    check_zero("midrst");
    exp_q.delete();
    frame_q.delete();
    show_on = 0;
    busy_prev = 0;
    pv = 0;
    pid = 0;
    pb = 0;
    @(posedge clk);
    #1;
    nRESET = 1'b1;
    mon_en = 1;
  endtask

  initial begin
    bit         rv;
    logic [7:0] rd;
    int         last_id;
    int         r;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    bus.test_req = 1'b0;
    bus.test_id = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    nRESET = 1'b1;
    mon_en = 1;

    idle(3);
    send(8'hA5); send(8'h07); send(8'hA2);
    idle(12);
    send(8'hA5); send(8'h07); send(8'hA3);
    idle(4);
    send(8'hA5); send(8'hC1); send(8'hA5); send(8'h03); send(8'hA6);
    idle(12);
    send(8'hA5);
    idle(20);
    send(8'hA5); send(8'h05); send(8'hA0);
    idle(12);

    treq_lvl = 1;
    tid_lvl = 6'd9;
    idle(3);
    send(8'hA5); send(8'h0A); send(8'hAF);
    idle(25);
    treq_lvl = 0;
    idle(12);

    send(8'hA5); send(8'h04);
    do_reset();
    send(8'h04); send(8'hA1);
    idle(4);
    send(8'hA5); send(8'h06); send(8'hA3);
    idle(3);
    do_reset();
    idle(4);

    last_id = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) treq_lvl = !treq_lvl;
      tid_lvl = 6'($urandom_range(63));
      if ($urandom_range(999) == 0) begin
        do_reset();
      end else if ($urandom_range(199) == 0) begin
        idle(20);
      end else if ($urandom_range(19) == 0) begin
        last_id = $urandom_range(63);
        send(HDR);
        idle($urandom_range(3));
        send(8'(last_id));
        idle($urandom_range(3));
        send(HDR ^ 8'(last_id));
      end else begin
        rv = ($urandom_range(99) < 35);
        r = $urandom_range(9);
        if (r <= 2) rd = HDR;
        else if (r <= 5) begin
          last_id = $urandom_range(63);
          rd = 8'(last_id);
        end else if (r <= 7) rd = HDR ^ 8'(last_id);
        else if (r == 8) rd = 8'($urandom_range(255));
        else rd = 8'($urandom_range(255, 64));
        cycle(rv, rd);
      end
    end

    treq_lvl = 0;
    idle(40);
    cmp("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
